// File: rtl/jtag_tap_pkg.sv
// Shared types and helpers for the sampled JTAG TAP: state encoding, fixed
// instruction opcodes and the IEEE 1149.1 next-state function.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TAP_TLR      = 4'd0,
    TAP_RTI      = 4'd1,
    TAP_SEL_DR   = 4'd2,
    TAP_CAP_DR   = 4'd3,
    TAP_SHIFT_DR = 4'd4,
    TAP_EXIT1_DR = 4'd5,
    TAP_PAUSE_DR = 4'd6,
    TAP_EXIT2_DR = 4'd7,
    TAP_UPD_DR   = 4'd8,
    TAP_SEL_IR   = 4'd9,
    TAP_CAP_IR   = 4'd10,
    TAP_SHIFT_IR = 4'd11,
    TAP_EXIT1_IR = 4'd12,
    TAP_PAUSE_IR = 4'd13,
    TAP_EXIT2_IR = 4'd14,
    TAP_UPD_IR   = 4'd15
  } tap_state_e;

  // Opcodes are truncated to the actual IR length at the point of use.
  localparam logic [31:0] IR_IDCODE = 32'h0000_0001;
  localparam logic [31:0] IR_BYPASS = 32'hFFFF_FFFF;

  function automatic tap_state_e tap_next(input tap_state_e state, input logic tms);
    tap_state_e nxt;
    nxt = TAP_TLR;
    case (state)
      TAP_TLR:      nxt = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      nxt = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   nxt = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: nxt = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: nxt = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: nxt = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   nxt = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   nxt = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: nxt = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: nxt = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: nxt = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   nxt = tms ? TAP_SEL_DR   : TAP_RTI;
      default:      nxt = TAP_TLR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_tap_sync.sv
// Two-flop synchronizer bank for bringing the asynchronous JTAG pins into clk_i.
module jtag_tap_sync #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_meta;
  logic [Width-1:0] r_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/jtag_tap_sampled.sv
// Oversampled JTAG TAP: pins synchronized into clk_i, TAP FSM advanced on detected
// TCK edges, with IDCODE, BYPASS and one USER data register behind a capture/update port.
module jtag_tap_sampled
  import jtag_tap_pkg::*;
#(
  parameter int unsigned          IrLength    = 5,
  parameter logic [31:0]          IdcodeValue = 32'h0000_0001,
  parameter int unsigned          UserDrWidth = 32,
  parameter logic [IrLength-1:0]  UserIr      = IrLength'(5'h10)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   jtag_tck_i,
  input  logic                   jtag_tms_i,
  input  logic                   jtag_tdi_i,
  input  logic                   jtag_trst_ni,
  output logic                   jtag_tdo_o,
  output logic                   jtag_tdo_oe_o,
  output logic [3:0]             tap_state_o,
  output logic [IrLength-1:0]    ir_o,
  output logic                   user_capture_req_o,
  input  logic [UserDrWidth-1:0] user_capture_i,
  output logic                   user_update_valid_o,
  output logic [UserDrWidth-1:0] user_update_o
);

  localparam logic [IrLength-1:0] IrIdcode = IrLength'(IR_IDCODE);

  logic [3:0] w_pins;
  logic       w_tck;
  logic       w_tms;
  logic       w_tdi;
  logic       w_trst_n;
  logic       w_tck_rise;
  logic       w_tck_fall;
  logic       w_sel_idcode;
  logic       w_sel_user;
  logic       w_dr_lsb;
  tap_state_e w_state_nxt;

  logic                   r_tck_q;
  tap_state_e             r_state;
  logic [IrLength-1:0]    r_ir;
  logic [IrLength-1:0]    r_ir_sr;
  logic [31:0]            r_idcode_sr;
  logic                   r_bypass_sr;
  logic [UserDrWidth-1:0] r_user_sr;
  logic [UserDrWidth-1:0] r_user_update;
  logic                   r_tdo;
  logic                   r_tdo_oe;
  logic                   r_cap_req;
  logic                   r_upd_valid;

  function automatic logic [UserDrWidth-1:0] shift_user(input logic [UserDrWidth-1:0] v,
                                                        input logic b);
    return (v >> 1) | (UserDrWidth'(b) << (UserDrWidth - 1));
  endfunction

  jtag_tap_sync #(.Width(4)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_d    ({jtag_trst_ni, jtag_tdi_i, jtag_tms_i, jtag_tck_i}),
    .o_q    (w_pins)
  );

  assign {w_trst_n, w_tdi, w_tms, w_tck} = w_pins;
  assign w_tck_rise   = w_tck & ~r_tck_q;
  assign w_tck_fall   = ~w_tck & r_tck_q;
  assign w_state_nxt  = tap_next(r_state, w_tms);
  assign w_sel_idcode = (r_ir == IrIdcode);
  assign w_sel_user   = (r_ir == UserIr) && !w_sel_idcode;
  assign w_dr_lsb     = w_sel_idcode ? r_idcode_sr[0] :
                        w_sel_user   ? r_user_sr[0]   : r_bypass_sr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_tck_q <= 1'b0;
    else         r_tck_q <= w_tck;
  end

  // TRST_n is checked before any TCK edge so a simultaneous edge is ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= TAP_TLR;
      r_ir          <= IrIdcode;
      r_ir_sr       <= '0;
      r_idcode_sr   <= '0;
      r_bypass_sr   <= 1'b0;
      r_user_sr     <= '0;
      r_user_update <= '0;
      r_tdo         <= 1'b0;
      r_tdo_oe      <= 1'b0;
      r_cap_req     <= 1'b0;
      r_upd_valid   <= 1'b0;
    end else if (!w_trst_n) begin
      r_state       <= TAP_TLR;
      r_ir          <= IrIdcode;
      r_ir_sr       <= '0;
      r_idcode_sr   <= '0;
      r_bypass_sr   <= 1'b0;
      r_user_sr     <= '0;
      r_user_update <= '0;
      r_tdo         <= 1'b0;
      r_tdo_oe      <= 1'b0;
      r_cap_req     <= 1'b0;
      r_upd_valid   <= 1'b0;
    end else begin
      r_cap_req   <= 1'b0;
      r_upd_valid <= 1'b0;
      // The consumer presents its capture value while the request pulse is high.
      if (r_cap_req) r_user_sr <= user_capture_i;

      if (w_tck_rise) begin
        case (r_state)
          TAP_CAP_IR:   r_ir_sr <= IrLength'(2'b01);
          TAP_SHIFT_IR: r_ir_sr <= {w_tdi, r_ir_sr[IrLength-1:1]};
          TAP_CAP_DR: begin
            if (w_sel_idcode)    r_idcode_sr <= IdcodeValue;
            else if (!w_sel_user) r_bypass_sr <= 1'b0;
          end
          TAP_SHIFT_DR: begin
            if (w_sel_idcode)    r_idcode_sr <= {w_tdi, r_idcode_sr[31:1]};
            else if (w_sel_user) r_user_sr   <= shift_user(r_user_sr, w_tdi);
            else                 r_bypass_sr <= w_tdi;
          end
          default: ;
        endcase
        r_state <= w_state_nxt;
        if (w_state_nxt == TAP_TLR) r_ir <= IrIdcode;
        if (w_state_nxt == TAP_CAP_DR && w_sel_user) r_cap_req <= 1'b1;
      end

      if (w_tck_fall) begin
        case (r_state)
          TAP_SHIFT_IR: begin
            r_tdo    <= r_ir_sr[0];
            r_tdo_oe <= 1'b1;
          end
          TAP_SHIFT_DR: begin
            r_tdo    <= w_dr_lsb;
            r_tdo_oe <= 1'b1;
          end
          default: begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
          end
        endcase
        if (r_state == TAP_UPD_IR) r_ir <= r_ir_sr;
        if (r_state == TAP_UPD_DR && w_sel_user) begin
          r_user_update <= r_user_sr;
          r_upd_valid   <= 1'b1;
        end
      end
    end
  end

  assign jtag_tdo_o          = r_tdo;
  assign jtag_tdo_oe_o       = r_tdo_oe;
  assign tap_state_o         = r_state;
  assign ir_o                = r_ir;
  assign user_capture_req_o  = r_cap_req;
  assign user_update_valid_o = r_upd_valid;
  assign user_update_o       = r_user_update;

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Bench for jtag_tap_sampled: drives TCK-level JTAG scans, tracks a bit-queue model of the
// TAP and checks outputs every settled cycle plus literal end-of-scan results.
module tb_jtag_tap_sampled;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tck = 1'b0;
  logic        tms = 1'b1;
  logic        tdi = 1'b0;
  logic        trst_n = 1'b1;
  logic [31:0] ucap = 32'h0;
  logic        tdo, tdo_oe, cap_req, upd_valid;
  logic [3:0]  state;
  logic [4:0]  ir;
  logic [31:0] uupd;

  always #5 clk = ~clk;

  jtag_tap_sampled dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .jtag_tck_i          (tck),
    .jtag_tms_i          (tms),
    .jtag_tdi_i          (tdi),
    .jtag_trst_ni        (trst_n),
    .jtag_tdo_o          (tdo),
    .jtag_tdo_oe_o       (tdo_oe),
    .tap_state_o         (state),
    .ir_o                (ir),
    .user_capture_req_o  (cap_req),
    .user_capture_i      (ucap),
    .user_update_valid_o (upd_valid),
    .user_update_o       (uupd)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: state numbering 0=TLR,1=RTI,2..8 DR column,9..15 IR column.
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  localparam logic [4:0]  USER_IR = 5'h10;
  localparam logic [31:0] IDCODE  = 32'h0000_0001;

  int          st = 0;
  logic [4:0]  m_ir = 5'h01;
  bit          qdr[$];
  bit          qir[$];
  logic        m_tdo = 1'b0;
  logic        m_oe = 1'b0;
  logic [31:0] m_uupd = 32'h0;
  int          m_updcnt = 0;
  int          m_capcnt = 0;
  int          dut_updcnt = 0;
  int          dut_capcnt = 0;
  bit          chk_en = 1'b0;

  task automatic model_rise(input logic t_ms, input logic t_di);
    logic [31:0] v;
    if (st == 3) begin
      qdr.delete();
      if (m_ir == 5'h01 || m_ir == USER_IR) begin
        v = (m_ir == 5'h01) ? IDCODE : ucap;
        for (int i = 0; i < 32; i++) qdr.push_back(v[i]);
      end else qdr.push_back(1'b0);
    end else if (st == 10) begin
      qir.delete();
      for (int i = 0; i < 5; i++) qir.push_back(i == 0);
    end else if (st == 4) begin
      qdr.push_back(t_di);
      void'(qdr.pop_front());
    end else if (st == 11) begin
      qir.push_back(t_di);
      void'(qir.pop_front());
    end
    st = t_ms ? nxt1[st] : nxt0[st];
    if (st == 0) m_ir = 5'h01;
    if (st == 3 && m_ir == USER_IR) m_capcnt++;
  endtask

  task automatic model_fall();
    m_tdo = 1'b0;
    m_oe  = 1'b0;
    if (st == 4) begin m_tdo = qdr[0]; m_oe = 1'b1; end
    if (st == 11) begin m_tdo = qir[0]; m_oe = 1'b1; end
    if (st == 15) for (int i = 0; i < 5; i++) m_ir[i] = qir[i];
    if (st == 8 && m_ir == USER_IR) begin
      for (int i = 0; i < 32; i++) m_uupd[i] = qdr[i];
      m_updcnt++;
    end
  endtask

  task automatic model_reset();
    st = 0; m_ir = 5'h01; m_tdo = 1'b0; m_oe = 1'b0; m_uupd = 32'h0;
  endtask

  // Per-cycle comparison once all pins have been stable for three clk periods.
  initial begin : cmp
    logic [1:0] last;
    int since;
    last = {tck, trst_n};
    since = 0;
    forever begin
      @(negedge clk);
      if (upd_valid) dut_updcnt++;
      if (cap_req) dut_capcnt++;
      if ({tck, trst_n} != last) begin
        last = {tck, trst_n};
        since = 0;
      end else if (since < 100) since++;
      if (chk_en && since >= 3) begin
        chk("cyc_state", 64'(state), 64'(st));
        chk("cyc_ir", 64'(ir), 64'(m_ir));
        chk("cyc_tdo", 64'(tdo), 64'(m_tdo));
        chk("cyc_oe", 64'(tdo_oe), 64'(m_oe));
        chk("cyc_uupd", 64'(uupd), 64'(m_uupd));
        chk("cyc_updcnt", 64'(dut_updcnt), 64'(m_updcnt));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  // One TCK period: TMS/TDI set at the previous fall, TDO sampled just before the rise.
  task automatic tck_cycle(input logic t_ms, input logic t_di, output logic so);
    tms = t_ms;
    tdi = t_di;
    repeat (4) @(posedge clk);
    #2;
    so = tdo;
    tck = 1'b1;
    model_rise(t_ms, t_di);
    repeat (4) @(posedge clk);
    #2;
    tck = 1'b0;
    model_fall();
  endtask

  task automatic scan_ir(input logic [4:0] din, output logic [4:0] dout);
    logic s;
    dout = '0;
    tck_cycle(1'b1, 1'b0, s);
    tck_cycle(1'b1, 1'b0, s);
    tck_cycle(1'b0, 1'b0, s);
    tck_cycle(1'b0, 1'b0, s);
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, din[i], s);
      dout[i] = s;
    end
    tck_cycle(1'b1, 1'b0, s);
    tck_cycle(1'b0, 1'b0, s);
  endtask

  task automatic scan_dr(input logic [63:0] din, input int n, input int pause_at,
                         output logic [63:0] dout);
    logic s;
    logic brk;
    dout = '0;
    tck_cycle(1'b1, 1'b0, s);
    tck_cycle(1'b0, 1'b0, s);
    if (n == 0) tck_cycle(1'b1, 1'b0, s);
    else begin
      tck_cycle(1'b0, 1'b0, s);
      for (int i = 0; i < n; i++) begin
        brk = (i == n - 1) || (i == pause_at - 1);
        tck_cycle(brk, din[i], s);
        dout[i] = s;
        if (i == pause_at - 1 && i != n - 1) begin
          repeat (10) tck_cycle(1'b0, 1'b0, s);
          tck_cycle(1'b1, 1'b0, s);
          tck_cycle(1'b0, 1'b0, s);
        end
      end
    end
    tck_cycle(1'b1, 1'b0, s);
    tck_cycle(1'b0, 1'b0, s);
  endtask

  initial begin : main
    logic [4:0]  iro;
    logic [63:0] dro;
    logic        s;

    #12;
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_ir", 64'(ir), 64'(5'h01));
    chk("rst_tdo", 64'(tdo), 64'(0));
    chk("rst_oe", 64'(tdo_oe), 64'(0));
    chk("rst_upd_valid", 64'(upd_valid), 64'(0));
    chk("rst_uupd", 64'(uupd), 64'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk_en = 1'b1;

    repeat (5) tck_cycle(1'b1, 1'b0, s);
    chk("tlr_state", 64'(state), 64'(0));
    chk("tlr_ir", 64'(ir), 64'(5'h01));
    chk("tlr_oe", 64'(tdo_oe), 64'(0));

    tck_cycle(1'b0, 1'b0, s);
    scan_dr(64'h0, 32, -1, dro);
    chk("idcode_dr", 64'(dro[31:0]), 64'(32'h0000_0001));

    scan_ir(5'h1F, iro);
    chk("ir_capture_a", 64'(iro), 64'(5'h01));
    chk("ir_bypass", 64'(ir), 64'(5'h1F));
    scan_dr(64'h0A5, 9, -1, dro);
    chk("bypass_dr", 64'(dro[8:0]), 64'(9'h14A));

    ucap = 32'hDEAD_BEEF;
    scan_ir(5'h10, iro);
    chk("ir_capture_b", 64'(iro), 64'(5'h01));
    chk("ir_user", 64'(ir), 64'(5'h10));
    scan_dr(64'h1234_5678, 32, -1, dro);
    chk("user_dr_out", 64'(dro[31:0]), 64'(32'hDEAD_BEEF));
    chk("user_upd_cnt", 64'(dut_updcnt), 64'(1));
    chk("user_cap_cnt", 64'(dut_capcnt), 64'(1));
    chk("user_update", 64'(uupd), 64'(32'h1234_5678));

    ucap = 32'h0BAD_F00D;
    scan_dr(64'h0, 0, -1, dro);
    chk("zero_len_update", 64'(uupd), 64'(32'h0BAD_F00D));
    chk("zero_len_cnt", 64'(dut_updcnt), 64'(2));

    tck_cycle(1'b1, 1'b0, s);
    tck_cycle(1'b0, 1'b0, s);
    tck_cycle(1'b0, 1'b0, s);
    repeat (4) tck_cycle(1'b0, 1'b1, s);
    chk("pre_trst_state", 64'(state), 64'(4));
    repeat (4) @(posedge clk);
    #2;
    trst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("trst_state", 64'(state), 64'(0));
    chk("trst_ir", 64'(ir), 64'(5'h01));
    chk("trst_oe", 64'(tdo_oe), 64'(0));
    chk("trst_uupd", 64'(uupd), 64'(0));
    tck = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    tck = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("trst_dominates", 64'(state), 64'(0));
    chk("trst_no_upd", 64'(dut_updcnt), 64'(2));
    trst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    tck_cycle(1'b0, 1'b0, s);

    scan_ir(5'h10, iro);
    ucap = 32'hCAFE_F00D;
    scan_dr(64'hA5C3_0F96, 32, 16, dro);
    chk("pause_dr_out", 64'(dro[31:0]), 64'(32'hCAFE_F00D));
    chk("pause_update", 64'(uupd), 64'(32'hA5C3_0F96));
    chk("pause_upd_cnt", 64'(dut_updcnt), 64'(3));
    chk("cap_cnt_model", 64'(dut_capcnt), 64'(m_capcnt));

    tck_cycle(1'b1, 1'b0, s);
    tck_cycle(1'b1, 1'b0, s);
    tck_cycle(1'b0, 1'b0, s);
    tck_cycle(1'b0, 1'b0, s);
    repeat (4) @(posedge clk);
    #2;
    chk("shift_ir_state", 64'(state), 64'(11));
    chk("shift_ir_oe", 64'(tdo_oe), 64'(1));
    repeat (5) tck_cycle(1'b1, 1'b1, s);
    repeat (4) @(posedge clk);
    #2;
    chk("five_tms_state", 64'(state), 64'(0));
    chk("five_tms_ir", 64'(ir), 64'(5'h01));
    chk("five_tms_oe", 64'(tdo_oe), 64'(0));

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
